// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: decode handshake, redirect and VEDA instruction-port bundle
interface instruction_fetch_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH = 4
);
   logic fetch_en;
   logic redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic instr_ready;
   logic instr_valid;
   logic [DATA_WIDTH-1:0] Instruction;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic [$clog2(DEPTH):0] queue_count;
   logic [ADDR_WIDTH-1:0] VEDA_address1;
   logic [DATA_WIDTH-1:0] VEDA_data_out1;
   logic [DATA_WIDTH-1:0] VEDA_data_in1;
   logic VEDA_mode1;
   modport master (
      output fetch_en, redirect_valid, redirect_pc, instr_ready, VEDA_data_out1,
      input instr_valid, Instruction, instr_pc, queue_count, VEDA_address1, VEDA_data_in1, VEDA_mode1
   );
   modport slave (
      input fetch_en, redirect_valid, redirect_pc, instr_ready, VEDA_data_out1,
      output instr_valid, Instruction, instr_pc, queue_count, VEDA_address1, VEDA_data_in1, VEDA_mode1
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: pipelined instruction fetch with credit-limited prefetch FIFO and redirect
module instruction_fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int MEM_LATENCY = 1,
   parameter int PC_STEP = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst,
   instruction_fetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] q_word [DEPTH];
   logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic pop, issue, wr_v;
   logic [ADDR_WIDTH-1:0] wr_pc;
   logic [7:0] inflight;
   assign bus.instr_valid = (count != '0) & ~bus.redirect_valid;
   assign pop = bus.instr_valid & bus.instr_ready;
   // Every issued read owns a queue slot until popped, so a returning word always finds room
   assign issue = bus.fetch_en & ~rst & ~bus.redirect_valid & (8'(count) + inflight - 8'(pop) < 8'(DEPTH));
   if (MEM_LATENCY == 1) begin : g_comb
      assign wr_v = issue;
      assign wr_pc = fetch_pc;
      assign inflight = '0;
   end else begin : g_pipe
      logic [MEM_LATENCY-2:0] st_v;
      logic [ADDR_WIDTH-1:0] st_pc [MEM_LATENCY-1];
      always_ff @(posedge clk) begin
         st_v[0] <= issue;
         st_pc[0] <= fetch_pc;
         for (int i = 1; i < MEM_LATENCY - 1; i++) begin
            st_v[i] <= st_v[i-1];
            st_pc[i] <= st_pc[i-1];
         end
         if (rst || bus.redirect_valid) st_v <= '0;
      end
      assign wr_v = st_v[MEM_LATENCY-2];
      assign wr_pc = st_pc[MEM_LATENCY-2];
      assign inflight = 8'($countones(st_v));
   end
   always_ff @(posedge clk) begin
      if (rst || bus.redirect_valid) begin
         fetch_pc <= rst ? RESET_PC : bus.redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
         if (wr_v) begin
            q_word[wr_ptr] <= bus.VEDA_data_out1;
            q_pc[wr_ptr] <= wr_pc;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(wr_v) - CW'(pop);
      end
   end
   always_ff @(posedge clk)
      if (!rst && !bus.redirect_valid) assert (!(wr_v && count == CW'(DEPTH) && !pop));
   assign bus.Instruction = q_word[rd_ptr];
   assign bus.instr_pc = q_pc[rd_ptr];
   assign bus.queue_count = count;
   assign bus.VEDA_address1 = fetch_pc;
   assign bus.VEDA_data_in1 = '0;
   assign bus.VEDA_mode1 = 1'b1;
endmodule
